sha256_msg_schedule: RTL and testbench

SHA-256 message-schedule stage that sits directly upstream of the round-compression logic. It accepts one 512-bit padded message block and then streams the 64 round inputs, W_t and K_t, one round per accepted beat. The round stage consumes these beats alongside its A..H working state. The block holds a 16-word sliding window and generates W_16..W_63 on the fly. It also contains the 64-entry K constant ROM.

---
 rtl/sha256_msg_schedule.sv | 79 +++++++
 tb/tb_sha256_msg_schedule.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one 512-bit block, then streams W_t/K_t for t=0..63.
// Round 0 is valid from the load edge; holds all outputs while in_ready_rnd is low.
module sha256_msg_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [511:0] in_block,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [31:0]  out_Wi,
  output logic [31:0]  out_Ki,
  output logic [5:0]   out_round,
  output logic         out_valid,
  output logic         out_last,
  input  logic         in_ready_rnd
);

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [31:0] w [16];
  logic [5:0]  round;
  logic        load, accept;
  logic [31:0] sig0, sig1, w_new;

  assign load   = (state == IDLE) && in_valid;
  assign accept = (state == RUN) && in_ready_rnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (accept && (round == 6'd63)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Generation runs every accepted beat, rounds 48..63 included; the extra words are simply dropped.
  assign sig0  = {w[1][6:0], w[1][31:7]} ^ {w[1][17:0], w[1][31:18]} ^ (w[1] >> 3);
  assign sig1  = {w[14][16:0], w[14][31:17]} ^ {w[14][18:0], w[14][31:19]} ^ (w[14] >> 10);
  assign w_new = sig1 + w[9] + sig0 + w[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (load) begin
      round <= '0;
      for (int i = 0; i < 16; i++) w[i] <= in_block[511 - 32*i -: 32];
    end else if (accept) begin
      round <= round + 6'd1;
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_new;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RUN);
  assign out_Wi    = out_valid ? w[0] : '0;
  assign out_Ki    = out_valid ? K_ROM[round] : '0;
  assign out_round = out_valid ? round : '0;
  assign out_last  = out_valid && (round == 6'd63);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Randomized bench for sha256_msg_schedule against a whole-block schedule model.
module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] in_block;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_Wi;
  logic [31:0]  out_Ki;
  logic [5:0]   out_round;
  logic         out_valid;
  logic         out_last;
  logic         in_ready_rnd;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_w [64];
  logic [31:0] obs_w [64];
  logic [31:0] obs_k [64];

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_msg_schedule dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_block     (in_block),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_Wi       (out_Wi),
    .out_Ki       (out_Ki),
    .out_round    (out_round),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .in_ready_rnd (in_ready_rnd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook schedule over the full 64-entry array.
  task automatic gen_model(input logic [511:0] b);
    for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      logic [31:0] s0, s1;
      s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
      s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
      exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_out_wi"},    out_Wi,         32'd0);
    chk({tag, "_out_ki"},    out_Ki,         32'd0);
    chk({tag, "_out_round"}, 32'(out_round), 32'd0);
  endtask

  // Entered and left at a negedge. hold keeps in_valid high after the load; abort_at >= 0 resets mid-block.
  task automatic run_block(input string tag, input logic [511:0] b, input int stall_pct,
                           input bit hold, input int abort_at);
    int t;
    int cyc;
    gen_model(b);
    chk({tag, "_pre_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_pre_out_valid"}, 32'(out_valid), 32'd0);
    in_block     = b;
    in_valid     = 1'b1;
    in_ready_rnd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    t = 0;
    for (cyc = 0; cyc < 2000 && t < 64; cyc++) begin
      if (t == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk_idle({tag, "_async_rst"});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle({tag, "_after_rst"});
        return;
      end
      chk($sformatf("%s_valid_r%0d", tag, t), 32'(out_valid), 32'd1);
      chk($sformatf("%s_in_ready_r%0d", tag, t), 32'(in_ready), 32'd0);
      chk($sformatf("%s_round_r%0d", tag, t), 32'(out_round), 32'(t));
      chk($sformatf("%s_w_r%0d", tag, t), out_Wi, exp_w[t]);
      chk($sformatf("%s_k_r%0d", tag, t), out_Ki, K_TAB[t]);
      chk($sformatf("%s_last_r%0d", tag, t), 32'(out_last), 32'(t == 63));
      obs_w[t] = out_Wi;
      obs_k[t] = out_Ki;
      in_ready_rnd = ($urandom_range(99) >= stall_pct);
      @(posedge clk);
      if (in_ready_rnd) t++;
      @(negedge clk);
    end
    in_ready_rnd = 1'b0;
    chk({tag, "_timeout"}, 32'(t), 32'd64);
    chk_idle({tag, "_post"});
  endtask

  logic [511:0] abc_blk;
  logic [511:0] r1, r2, r3;

  initial begin
    abc_blk = {32'h61626380, 448'h0, 32'h00000018};
    for (int i = 0; i < 16; i++) begin
      r1[511 - 32*i -: 32] = $urandom;
      r2[511 - 32*i -: 32] = $urandom;
      r3[511 - 32*i -: 32] = $urandom;
    end
    rst_n        = 1'b0;
    in_block     = '0;
    in_valid     = 1'b0;
    in_ready_rnd = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("reset_release");

    run_block("abc", abc_blk, 0, 1'b0, -1);
    chk("abc_w0",  obs_w[0],  32'h61626380);
    chk("abc_w15", obs_w[15], 32'h00000018);
    chk("abc_w16", obs_w[16], 32'h61626380);
    chk("abc_w17", obs_w[17], 32'h000f0000);
    chk("abc_k0",  obs_k[0],  32'h428a2f98);
    chk("abc_k1",  obs_k[1],  32'h71374491);
    chk("abc_k63", obs_k[63], 32'hc67178f2);

    run_block("abc_stall", abc_blk, 50, 1'b0, -1);

    // in_valid stays high through block 1, so block 2 must load on the single bubble edge.
    run_block("b2b_1", r1, 0, 1'b1, -1);
    run_block("b2b_2", r2, 30, 1'b0, -1);

    run_block("abort", abc_blk, 0, 1'b0, 30);
    run_block("abc_after_rst", abc_blk, 0, 1'b0, -1);

    run_block("ones", {16{32'hffffffff}}, 50, 1'b0, -1);
    run_block("rand", r3, 40, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
